clk_gen_multi: RTL and testbench
================================

# clk_gen_multi

Multi-channel programmable clock generator for the CAN timing-analysis datapath. It produces NUM_CH independent divided clocks from clk, each with its own high time, low time and start phase. Configuration is written through a valid/ready port into per-channel shadow registers. Changes take effect only at a period boundary, so no output ever produces a runt pulse. Downstream bit-timing and sampling logic consumes clk_out, the per-channel rise strobes and the count values.

## Interface
Parameters:
- NUM_CH, 4, number of independent clock channels (1..16)
- CNT_W, 23, width of the high/low/phase counters, in clk cycles

Ports:
- clk  input  1  system clock (10 ns); all logic on posedge
- resetN  input  1  reset resetN, synchronous, active-low; clock clk
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  combinational: !pending[cfg_ch]
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel
- cfg_en  input  1  1 = run channel, 0 = stop channel
- cfg_high  input  CNT_W  high-phase length in cycles; 0 is treated as 1
- cfg_low  input  CNT_W  low-phase length in cycles; 0 is treated as 1
- cfg_phase  input  CNT_W  idle-low delay in cycles before the first high phase after enable
- clk_out  output  NUM_CH  generated clocks, registered
- rise  output  NUM_CH  one-cycle strobe, high in the same cycle clk_out[i] goes 0→1
- active  output  NUM_CH  1 while channel state ≠ IDLE
- count  output  NUM_CH*CNT_W  per-channel in-phase counter; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Per-channel state: shadow {en, high, low, phase}, pending bit, active {high, low}, FSM, count.
- A write is accepted on an edge where cfg_valid && cfg_ready. That edge loads the shadow of cfg_ch and sets pending. A write to a channel with pending=1 is stalled, not dropped.
- FSM states: IDLE, PHASE, HIGH, LOW.
- IDLE
  - clk_out=0 and count=0.
  - If pending and shadow.en: on the next edge, copy shadow to active, clear pending, and go to PHASE (phase>0) or HIGH (phase=0).
  - If pending and !shadow.en: clear pending and stay in IDLE.
- PHASE: clk_out=0. Count runs 0..phase-1. On the edge where count==phase-1, go to HIGH.
- HIGH: clk_out=1. Count runs 0..high-1. On the edge where count==high-1, go to LOW.
- LOW: clk_out=0. Count runs 0..low-1. On the edge where count==low-1 (the period boundary):
  - If pending and shadow.en: copy shadow.high/low to active, clear pending, go to HIGH. Phase is ignored while running.
  - If pending and !shadow.en: clear pending, go to IDLE.
  - Otherwise: go to HIGH with the current active config.
- Count resets to 0 on every state transition.
- Period = max(high,1) + max(low,1) cycles. Counter arithmetic is CNT_W-bit unsigned. Lengths of 0 and 1 are identical.
- Channels are fully independent. Only the config port is shared.

## Timing
- Reset values: clk_out=0, rise=0, active=0, count=0, pending=0, shadow/active config=0, FSM=IDLE. cfg_ready=1 after reset.
- Reset asserted mid-operation: all of the above take effect at the next edge. Any in-flight pending write is discarded.
- Idle channel, phase=0: write accepted at edge T, clk_out, rise and active all rise at edge T+1.
- Idle channel, phase=P>0: active rises at edge T+1, clk_out and rise at edge T+1+P.
- rise is asserted for exactly one cycle per HIGH entry.
- Running channel: a new config first affects the HIGH phase starting at the next boundary edge. A write accepted on the boundary edge itself is not used by that boundary; it waits for the following one.
- cfg_ready for a given channel is low from the acceptance edge until the edge that consumes pending.
- Stop via en=0: the channel finishes its current HIGH and LOW, then enters IDLE with clk_out=0. active falls at the boundary edge.

## Test plan
- Reset then idle: with resetN=0 for 3 cycles, all outputs must read 0 and cfg_ready=1. Release with no writes: outputs must stay 0 for 20 cycles.
- Basic divide: write ch0 {en=1, high=3, low=2, phase=0} at edge T. clk_out[0] must be high on T+1..T+3 and low on T+4..T+5, then repeat with period 5. rise[0] must pulse at T+1 and T+6.
- Phase and zero lengths: write ch1 {en=1, high=0, low=0, phase=4}. clk_out[1] must first rise at T+5, then toggle every cycle (period 2).
- Glitch-free reconfig: with ch0 running at 3/2, write {high=1, low=1} mid-HIGH. The current period must complete as 3/2, then switch to 1/1 starting exactly at the boundary. cfg_ready must be low for ch0 until that boundary. A second write held valid during that window must stall, then be accepted.
- Stop and boundary collision: write en=0 to ch0 on its boundary edge. One more full 3/2 period must occur, then clk_out=0 and active=0.
- Independence and reset mid-run: run all 4 channels at distinct configs and check each period. Assert resetN mid-HIGH: all outputs must be 0 on the next edge, and pending writes must be lost.

Source files
------------

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CH independent programmable divided clocks whose shadowed
// configuration is applied only at a period boundary, so no output produces a runt pulse.
module clk_gen_multi #(
   parameter int NUM_CH = 4,
   parameter int CNT_W = 23,
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic                    cfg_en,
   input  logic [CNT_W-1:0]        cfg_high,
   input  logic [CNT_W-1:0]        cfg_low,
   input  logic [CNT_W-1:0]        cfg_phase,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       rise,
   output logic [NUM_CH-1:0]       active,
   output logic [NUM_CH*CNT_W-1:0] count
);
   typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;
   logic [NUM_CH-1:0] pending;
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++)
         if (cfg_ch == CH_W'(c)) cfg_ready = !pending[c];
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t state, state_n;
      logic [CNT_W-1:0] cnt, sh_high, sh_low, sh_phase, a_high, a_low, a_phase, hi_last, lo_last;
      logic sh_en, pend, take, wr, clk_r, rise_r;
      assign wr = cfg_valid && cfg_ready && cfg_ch == CH_W'(i);
      // lengths of 0 and 1 both end the phase when the counter reads 0
      assign hi_last = a_high == '0 ? '0 : a_high - CNT_W'(1);
      assign lo_last = a_low == '0 ? '0 : a_low - CNT_W'(1);
      always_comb begin
         state_n = state;
         take = 1'b0;
         case (state)
            IDLE: if (pend) begin
               take = 1'b1;
               state_n = !sh_en ? IDLE : sh_phase != '0 ? PHASE : HIGH;
            end
            PHASE: state_n = cnt == a_phase - CNT_W'(1) ? HIGH : PHASE;
            HIGH: state_n = cnt == hi_last ? LOW : HIGH;
            default: if (cnt == lo_last) begin
               take = pend;
               state_n = pend && !sh_en ? IDLE : HIGH;
            end
         endcase
      end
      always_ff @(posedge clk)
         if (!resetN) begin
            state <= IDLE;
            cnt <= '0;
            pend <= 1'b0;
            clk_r <= 1'b0;
            rise_r <= 1'b0;
            {sh_en, sh_high, sh_low, sh_phase} <= '0;
            {a_high, a_low, a_phase} <= '0;
         end else begin
            state <= state_n;
            cnt <= state_n != state || state_n == IDLE ? '0 : cnt + CNT_W'(1);
            clk_r <= state_n == HIGH;
            rise_r <= state_n == HIGH && state != HIGH;
            pend <= wr || (pend && !take);
            if (wr) {sh_en, sh_high, sh_low, sh_phase} <= {cfg_en, cfg_high, cfg_low, cfg_phase};
            if (take) {a_high, a_low} <= {sh_high, sh_low};
            if (take && state == IDLE) a_phase <= sh_phase;
         end
      assign pending[i] = pend;
      assign clk_out[i] = clk_r;
      assign rise[i] = rise_r;
      assign active[i] = state != IDLE;
      assign count[i*CNT_W +: CNT_W] = cnt;
   end
endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: directed checks of divide, phase, boundary-only reconfig,
// stop, channel independence and reset for clk_gen_multi.
module tb_clk_gen_multi;
   logic clk = 1'b0;
   logic resetN, cfg_valid, cfg_ready, cfg_en;
   logic [1:0] cfg_ch;
   logic [22:0] cfg_high, cfg_low, cfg_phase;
   logic [3:0] clk_out, rise, active;
   logic [91:0] count;
   int checks = 0, passed = 0, fails = 0, cyc = 0;
   int t0, t1, t3;
   // ch0 trace from the mid-HIGH write through reconfig, stall, stop
   bit e_clk[22] = '{1,0,0,1,0,1,1,1,0,0,1,1,1,0,0,1,1,1,0,0,0,0};
   bit e_act[22] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
   bit e_rdy[22] = '{0,0,0,1,0,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,1,1};
   bit e_rise[22] = '{0,0,0,1,0,1,0,0,0,0,1,0,0,0,0,1,0,0,0,0,0,0};

   clk_gen_multi dut (
      .clk(clk), .resetN(resetN), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_high(cfg_high), .cfg_low(cfg_low),
      .cfg_phase(cfg_phase), .clk_out(clk_out), .rise(rise), .active(active), .count(count)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic en, input logic [22:0] h,
                     input logic [22:0] l, input logic [22:0] p);
      cfg_ch = ch; cfg_en = en; cfg_high = h; cfg_low = l; cfg_phase = p;
      cfg_valid = 1'b1;
      tick(1);
      cfg_valid = 1'b0;
   endtask

   initial begin
      resetN = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
      cfg_high = '0; cfg_low = '0; cfg_phase = '0;
      tick(3);
      chk("rst outputs", {clk_out, rise, active}, 0);
      chk("rst count", {63'b0, |count}, 0);
      chk("rst ready", cfg_ready, 1);
      resetN = 1'b1;
      for (int n = 0; n < 20; n++) begin
         tick(1);
         chk($sformatf("idle c%0d", n), {clk_out, rise, active, |count}, 0);
      end
      wr(2'd0, 1'b1, 23'd3, 23'd2, 23'd0);
      t0 = cyc;
      chk("ch0 ready after write", cfg_ready, 0);
      chk("ch0 inactive at write", active[0], 0);
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         chk($sformatf("ch0 clk/rise T+%0d", k), {clk_out[0], rise[0]},
             {((k - 1) % 5) < 3, ((k - 1) % 5) == 0});
         if (k <= 2) chk($sformatf("ch0 count T+%0d", k), count[22:0], k - 1);
      end
      wr(2'd1, 1'b1, 23'd0, 23'd0, 23'd4);
      t1 = cyc;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         chk($sformatf("ch1 clk/act T+%0d", k), {clk_out[1], active[1]},
             {k >= 5 && (k % 2) == 1, 1'b1});
         if (k == 4) chk("ch1 phase count", count[45:23], 3);
         if (k == 5 || k == 6) chk($sformatf("ch1 rise T+%0d", k), rise[1], k == 5);
      end
      for (int n = 0; n < 10 && ((cyc - t0 - 1) % 5) != 1; n++) tick(1);
      chk("ch0 mid-high", {clk_out[0], count[22:0]}, {1'b1, 23'd1});
      cfg_ch = 2'd0; cfg_en = 1'b1; cfg_high = 23'd1; cfg_low = 23'd1; cfg_phase = '0;
      cfg_valid = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick(1);
         chk($sformatf("ch0 reconfig E+%0d", k), {clk_out[0], active[0], cfg_ready, rise[0]},
             {e_clk[k-1], e_act[k-1], e_rdy[k-1], e_rise[k-1]});
         if (k == 1) begin cfg_high = 23'd3; cfg_low = 23'd2; end
         if (k == 5 || k == 16) cfg_valid = 1'b0;
         if (k == 15) begin cfg_en = 1'b0; cfg_valid = 1'b1; end
      end
      wr(2'd2, 1'b1, 23'd2, 23'd3, 23'd1);
      t3 = cyc;
      wr(2'd3, 1'b1, 23'd5, 23'd1, 23'd0);
      for (int j = 2; j <= 21; j++) begin
         tick(1);
         chk($sformatf("all clk j%0d", j), clk_out,
             {((j - 2) % 6) < 5, ((j - 2) % 5) < 2,
              (cyc - t1) >= 5 && ((cyc - t1 - 5) % 2) == 0, 1'b0});
         if (j == 2) chk("all active", active, 4'b1110);
      end
      cfg_ch = 2'd2; cfg_en = 1'b1; cfg_high = 23'd1; cfg_low = 23'd1; cfg_phase = '0;
      cfg_valid = 1'b1;
      tick(1);
      chk("ch2 pending before reset", cfg_ready, 0);
      cfg_valid = 1'b0;
      resetN = 1'b0;
      tick(1);
      chk("midrun rst outputs", {clk_out, rise, active, |count}, 0);
      chk("midrun rst ready", cfg_ready, 1);
      resetN = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick(1);
         chk($sformatf("post rst idle c%0d", n), {clk_out, active}, 0);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
